countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter MAX_MIN_TENS, default 9, the highest legal minutes-tens BCD digit (range 1..9).
REQ-002 The block SHALL have port clk_cin  input  1  system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk_cin.
REQ-004 The block SHALL have port tick  input  1  one-cycle count-enable pulse, one per second.
REQ-005 The block SHALL have port load  input  1  preset load strobe.
REQ-006 The block SHALL have port start  input  1  run/resume request.
REQ-007 The block SHALL have port pause  input  1  pause request.
REQ-008 The block SHALL have port preset  input  16  BCD MM:SS, nibbles [15:12] min-tens, [11:8] min-ones, [7:4] sec-tens, [3:0] sec-ones.
REQ-009 The block SHALL have port out  output  16  current BCD count, same nibble order as preset.
REQ-010 The block SHALL have port running  output  1  high while in RUN.
REQ-011 The block SHALL have port expired  output  1  high while in EXPIRED.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on reaching terminal count.

Function
REQ-013 The block SHALL use states IDLE, RUN, PAUSE and EXPIRED.
REQ-014 Input priority SHALL be rst > load > pause > start > tick, with one action per cycle.
REQ-015 On load in any state the block SHALL:
- write the clamped preset to count and to an internal reload register;
- enter IDLE;
- clear expired.
REQ-016 Clamping SHALL be per digit:
- sec-ones and min-ones > 9 become 9;
- sec-tens > 5 becomes 5;
- min-tens > MAX_MIN_TENS becomes MAX_MIN_TENS.
REQ-017 start SHALL move IDLE with a nonzero count to RUN, and PAUSE to RUN; start SHALL be ignored in IDLE with count 00:00, in RUN and in EXPIRED.
REQ-018 pause SHALL move RUN to PAUSE and SHALL be ignored in all other states.
REQ-019 When start and pause are both asserted in the same cycle, the block SHALL apply pause only.
REQ-020 A tick in RUN with no higher-priority input SHALL decrement the count by one second, taking effect at that edge.
REQ-021 Decrement borrow rules SHALL be:
- sec-ones 0 -> 9 with borrow;
- sec-tens 0 -> 5 with borrow;
- min-ones 0 -> 9 with borrow;
- min-tens decrements on borrow.
REQ-022 A tick in IDLE, PAUSE or EXPIRED, or one lost to a higher-priority input, SHALL be dropped and never deferred.
REQ-023 At the edge where a tick in RUN takes count from 00:01 to 00:00, the block SHALL enter EXPIRED and register done = 1 for exactly one cycle.
REQ-024 In EXPIRED, count SHALL hold 00:00 and only load or rst SHALL leave the state.
REQ-025 The outputs out, running, expired and done SHALL be registered, with no combinational path from any input.

Reset
REQ-026 rst SHALL set count = 16'h0000, the reload register = 16'h0000, state = IDLE, and running = expired = done = 0 on the next clock edge, overriding all coincident inputs in every state.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL control auto-reload.
- When defined: a tick in RUN at count 00:01 with a nonzero reload register SHALL load the reload register into count, keep RUN, pulse done for one cycle, and leave expired at 0; 00:00 is never displayed.
- When defined with a zero reload register: behaviour SHALL follow REQ-023.
- When not defined: no reload register is synthesised and REQ-023 applies unconditionally.

Verification
REQ-028 load preset 16'h0100, start, one tick -> out = 16'h0059, running = 1.
REQ-029 load 16'h0002, start, two ticks -> out = 16'h0000, done high for exactly 1 cycle, expired = 1, running = 0; a further tick or start leaves out = 16'h0000.
REQ-030 load 16'h1000, start, pause, five ticks -> out stays 16'h1000; start, one tick -> out = 16'h0959.
REQ-031 load 16'hFA6C with MAX_MIN_TENS = 9 -> out = 16'h9959; start with pause in the same cycle -> state PAUSE not entered from IDLE, stays IDLE, running = 0.
REQ-032 In RUN, assert rst together with tick, load and start -> next cycle out = 16'h0000, IDLE, all flags 0.
REQ-033 With COUNTDOWN_AUTO_RELOAD_EN defined: load 16'h0002, start, two ticks -> out = 16'h0002, done pulse of 1 cycle, running = 1, expired = 0.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with load/start/pause control and registered status flags.
// Optional auto-reload on terminal count is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer #(
  parameter int unsigned MAX_MIN_TENS = 9
) (
  input  logic        clk_cin,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic [15:0] preset,
  output logic [15:0] out,
  output logic        running,
  output logic        expired,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

  state_t      state;
  logic [15:0] count;
  logic [15:0] preset_clamped;
  logic [15:0] count_dec;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] reload;
`endif

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  always_comb begin
    preset_clamped = {clamp_digit(preset[15:12], MT_MAX),
                      clamp_digit(preset[11:8],  4'd9),
                      clamp_digit(preset[7:4],   4'd5),
                      clamp_digit(preset[3:0],   4'd9)};
  end

  // BCD decrement with borrow ripple; only used while the count is nonzero.
  always_comb begin
    count_dec = count;
    if (count[3:0] != 4'd0) begin
      count_dec[3:0] = count[3:0] - 4'd1;
    end else begin
      count_dec[3:0] = 4'd9;
      if (count[7:4] != 4'd0) begin
        count_dec[7:4] = count[7:4] - 4'd1;
      end else begin
        count_dec[7:4] = 4'd5;
        if (count[11:8] != 4'd0) begin
          count_dec[11:8] = count[11:8] - 4'd1;
        end else begin
          count_dec[11:8]  = 4'd9;
          count_dec[15:12] = count[15:12] - 4'd1;
        end
      end
    end
  end

  // Strict priority: an asserted higher-priority input consumes the cycle even if ignored.
  always_ff @(posedge clk_cin) begin
    done <= 1'b0;
    if (rst) begin
      count   <= 16'h0000;
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload  <= 16'h0000;
`endif
    end else if (load) begin
      count   <= preset_clamped;
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload  <= preset_clamped;
`endif
    end else if (pause) begin
      if (state == RUN) begin
        state   <= PAUSE;
        running <= 1'b0;
      end
    end else if (start) begin
      if ((state == IDLE && count != 16'h0000) || state == PAUSE) begin
        state   <= RUN;
        running <= 1'b1;
      end
    end else if (tick && state == RUN) begin
      if (count == 16'h0001) begin
        done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (reload != 16'h0000) begin
          count <= reload;
        end else
`endif
        begin
          count   <= 16'h0000;
          state   <= EXPIRED;
          running <= 1'b0;
          expired <= 1'b1;
        end
      end else begin
        count <= count_dec;
      end
    end
  end

  assign out = count;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer; reference model tracks the count as plain seconds.
module tb_countdown_timer;

  localparam int MAX_MT = 9;

  logic        clk_cin = 1'b0;
  logic        rst = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [15:0] out;
  logic        running, expired, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 run, 2 paused, 3 expired.
  int m_sec  = 0;
  int m_rel  = 0;
  int m_mode = 0;
  bit m_done = 1'b0;

  countdown_timer #(.MAX_MIN_TENS(MAX_MT)) dut (
    .clk_cin(clk_cin), .rst(rst), .tick(tick), .load(load), .start(start),
    .pause(pause), .preset(preset), .out(out), .running(running),
    .expired(expired), .done(done)
  );

  always #5 clk_cin = ~clk_cin;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int preset_to_sec(input logic [15:0] p);
    int mt, mo, st, so;
    mt = min_i(int'(p[15:12]), MAX_MT);
    mo = min_i(int'(p[11:8]), 9);
    st = min_i(int'(p[7:4]), 5);
    so = min_i(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model(input bit r, input bit l, input bit p, input bit s, input bit t,
                       input logic [15:0] pre);
    bit auto_rl;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    auto_rl = 1'b1;
`else
    auto_rl = 1'b0;
`endif
    m_done = 1'b0;
    if (r) begin
      m_sec = 0; m_rel = 0; m_mode = 0;
    end else if (l) begin
      m_sec = preset_to_sec(pre); m_rel = m_sec; m_mode = 0;
    end else if (p) begin
      if (m_mode == 1) m_mode = 2;
    end else if (s) begin
      if ((m_mode == 0 && m_sec != 0) || m_mode == 2) m_mode = 1;
    end else if (t && m_mode == 1) begin
      if (m_sec == 1) begin
        m_done = 1'b1;
        if (auto_rl && m_rel != 0) m_sec = m_rel;
        else begin
          m_sec = 0; m_mode = 3;
        end
      end else begin
        m_sec = m_sec - 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit p, input bit s, input bit t,
                      input logic [15:0] pre);
    rst = r; load = l; pause = p; start = s; tick = t; preset = pre;
    @(posedge clk_cin);
    model(r, l, p, s, t, pre);
    #1;
    chk("m_out",     out,            to_bcd(m_sec));
    chk("m_running", 16'(running),   16'(m_mode == 1));
    chk("m_expired", 16'(expired),   16'(m_mode == 3));
    chk("m_done",    16'(done),      16'(m_done));
    rst = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0; tick = 1'b0;
  endtask

  initial begin
    #2;
    step(1, 0, 0, 0, 0, 16'h0);
    chk("rst_out", out, 16'h0000);
    chk("rst_flags", {13'd0, running, expired, done}, 16'h0000);

    // 01:00 -> 00:59
    step(0, 1, 0, 0, 0, 16'h0100);
    step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("r28_out", out, 16'h0059);
    chk("r28_running", 16'(running), 16'h1);

    // 00:02 down to terminal
    step(0, 1, 0, 0, 0, 16'h0002);
    step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("r33_out", out, 16'h0002);
    chk("r33_done", 16'(done), 16'h1);
    chk("r33_running", 16'(running), 16'h1);
    chk("r33_expired", 16'(expired), 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    chk("r33_done_clr", 16'(done), 16'h0);
`else
    chk("r29_out", out, 16'h0000);
    chk("r29_done", 16'(done), 16'h1);
    chk("r29_expired", 16'(expired), 16'h1);
    chk("r29_running", 16'(running), 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    chk("r29_done_clr", 16'(done), 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("r29_tick_hold", out, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0);
    chk("r29_start_hold", out, 16'h0000);
    chk("r29_start_run", 16'(running), 16'h0);
`endif

    // pause freezes the count
    step(0, 1, 0, 0, 0, 16'h1000);
    step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 16'h0);
    chk("r30_paused", out, 16'h1000);
    step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("r30_resume", out, 16'h0959);

    // clamping, and start+pause in IDLE does nothing
    step(0, 1, 0, 0, 0, 16'hFA6C);
    chk("r31_clamp", out, 16'h9959);
    step(0, 0, 1, 1, 0, 16'h0);
    chk("r31_idle", 16'(running), 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("r31_no_tick", out, 16'h9959);

    // reset beats everything
    step(0, 1, 0, 0, 0, 16'h0005);
    step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    step(1, 1, 0, 1, 1, 16'h0300);
    chk("r32_out", out, 16'h0000);
    chk("r32_flags", {13'd0, running, expired, done}, 16'h0000);

    for (int i = 0; i < 4000; i++) begin
      logic [15:0] pre;
      int r;
      r   = int'($urandom_range(0, 99));
      pre = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {12'h000, 4'($urandom_range(1, 4))};
      step(r < 1,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 50,
           pre);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
